// File: rtl/mem_bus_responder_if.sv
// Strobe bus between the CPU controller, the memory responder and the external ROM.
interface mem_bus_responder_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              ram_ena;
    logic              ram_read;
    logic              ram_write;
    logic              rom_ena;
    logic              rom_read;
    logic              ad_sel;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdy;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [DATA_W-1:0] rom_q;

    modport slave (
        input  ram_ena, ram_read, ram_write, rom_ena, rom_read, ad_sel,
        input  pc_addr, ir_addr, wdata, rom_q,
        output rdata, rdy, busy, err, rom_addr, rom_rd
    );

    modport master (
        output ram_ena, ram_read, ram_write, rom_ena, rom_read, ad_sel,
        output pc_addr, ir_addr, wdata,
        input  rdata, rdy, busy, err
    );

    modport rom (
        input  rom_addr, rom_rd,
        output rom_q
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Decodes controller strobes into internal-RAM or external-ROM accesses with
// wait states, returning data with a one-cycle rdy pulse.
module mem_bus_responder #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int RAM_AW  = 8,
    parameter int RAM_WS  = 0,
    parameter int ROM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_bus_responder_if.slave bus
);

    // state      | meaning
    // S_IDLE     | waiting for a request
    // S_RAM_WAIT | RAM wait states counting down
    // S_RAM_ACC  | RAM access commits on the next edge
    // S_ROM_WAIT | waiting out external ROM latency
    // S_DONE     | rdy cycle, back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_WAIT,
        S_RAM_ACC,
        S_ROM_WAIT,
        S_DONE
    } state_t;

    localparam bit         LP_HAS_WS  = (RAM_WS > 0);
    localparam logic [3:0] LP_RAM_CNT = LP_HAS_WS ? 4'(RAM_WS - 1) : 4'd0;
    localparam logic [3:0] LP_ROM_CNT = 4'(ROM_LAT - 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [RAM_AW-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rdy;
    logic                r_busy;
    logic                r_err;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_rom_rd;
    logic [DATA_W-1:0]   r_mem [2**RAM_AW];

    logic                w_ram_ok;
    logic                w_ram_bad;
    logic                w_rom_req;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_commit_wr;

    assign w_ram_ok    = bus.ram_ena & (bus.ram_read ^ bus.ram_write);
    assign w_ram_bad   = bus.ram_ena & ~(bus.ram_read ^ bus.ram_write);
    assign w_rom_req   = bus.rom_ena & bus.rom_read;
    assign w_sel_addr  = bus.ad_sel ? bus.ir_addr : bus.pc_addr;
    assign w_commit_wr = (r_state == S_RAM_ACC) && r_wr && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_rdata    <= '0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rom_addr <= '0;
            r_rom_rd   <= 1'b0;
        end else begin
            r_rdy    <= 1'b0;
            r_rom_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ram_bad || (w_ram_ok && w_rom_req))
                        r_err <= 1'b1;
                    if (w_ram_ok) begin
                        r_idx   <= w_sel_addr[RAM_AW-1:0];
                        r_wdata <= bus.wdata;
                        r_wr    <= bus.ram_write;
                        r_busy  <= 1'b1;
                        r_cnt   <= LP_RAM_CNT;
                        r_state <= LP_HAS_WS ? S_RAM_WAIT : S_RAM_ACC;
                    end else if (w_rom_req) begin
                        r_rom_addr <= w_sel_addr;
                        r_rom_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= LP_ROM_CNT;
                        r_state    <= S_ROM_WAIT;
                    end
                end
                S_RAM_WAIT: begin
                    if (r_cnt == 4'd0)
                        r_state <= S_RAM_ACC;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                S_RAM_ACC: begin
                    if (!r_wr)
                        r_rdata <= r_mem[r_idx];
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_ROM_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= bus.rom_q;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is deliberately not reset; an aborted write never reaches the commit edge.
    always_ff @(posedge clk) begin
        if (w_commit_wr)
            r_mem[r_idx] <= r_wdata;
    end

    assign bus.rdata    = r_rdata;
    assign bus.rdy      = r_rdy;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_rd   = r_rom_rd;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responders with different wait-state settings share one clock.
module tb_mem_bus_responder;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   n_checks;
    int   n_errors;

    mem_bus_responder_if #(.ADDR_W(13), .DATA_W(8)) bus_a ();
    mem_bus_responder_if #(.ADDR_W(13), .DATA_W(8)) bus_b ();
    mem_bus_responder_if #(.ADDR_W(13), .DATA_W(8)) bus_c ();

    mem_bus_responder #(.ADDR_W(13), .DATA_W(8), .RAM_AW(8), .RAM_WS(0), .ROM_LAT(3))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    mem_bus_responder #(.ADDR_W(13), .DATA_W(8), .RAM_AW(8), .RAM_WS(2), .ROM_LAT(1))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));
    mem_bus_responder #(.ADDR_W(13), .DATA_W(8), .RAM_AW(8), .RAM_WS(3), .ROM_LAT(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(bus_c.slave));

    // ROM model: data = low address byte ^ 8'h38 (addr 4 -> 3C, addr 7 -> 3F)
    assign bus_a.rom_q = bus_a.rom_addr[7:0] ^ 8'h38;
    assign bus_b.rom_q = bus_b.rom_addr[7:0] ^ 8'h38;
    assign bus_c.rom_q = bus_c.rom_addr[7:0] ^ 8'h38;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.ram_ena = 0; bus_a.ram_read = 0; bus_a.ram_write = 0; bus_a.rom_ena = 0;
        bus_a.rom_read = 0; bus_a.ad_sel = 0; bus_a.pc_addr = 0; bus_a.ir_addr = 0; bus_a.wdata = 0;
        bus_b.ram_ena = 0; bus_b.ram_read = 0; bus_b.ram_write = 0; bus_b.rom_ena = 0;
        bus_b.rom_read = 0; bus_b.ad_sel = 0; bus_b.pc_addr = 0; bus_b.ir_addr = 0; bus_b.wdata = 0;
        bus_c.ram_ena = 0; bus_c.ram_read = 0; bus_c.ram_write = 0; bus_c.rom_ena = 0;
        bus_c.rom_read = 0; bus_c.ad_sel = 0; bus_c.pc_addr = 0; bus_c.ir_addr = 0; bus_c.wdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdata", bus_a.rdata, 0);
        chk("rst_rdy", bus_a.rdy, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_err", bus_a.err, 0);
        chk("rst_rom_addr", bus_a.rom_addr, 0);
        chk("rst_rom_rd", bus_a.rom_rd, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);

        // ---- DUT A (RAM_WS=0, ROM_LAT=3): write A5 to ir_addr 0x0010
        bus_a.ram_ena = 1; bus_a.ram_write = 1; bus_a.ad_sel = 1;
        bus_a.ir_addr = 13'h0010; bus_a.pc_addr = 13'h0099; bus_a.wdata = 8'hA5;
        @(negedge clk);
        chk("a_wr_busy", bus_a.busy, 1);
        chk("a_wr_rdy_early", bus_a.rdy, 0);
        bus_a.ram_ena = 0; bus_a.ram_write = 0; bus_a.ir_addr = 0; bus_a.wdata = 0;
        @(negedge clk);
        chk("a_wr_rdy", bus_a.rdy, 1);
        chk("a_wr_busy_end", bus_a.busy, 0);
        chk("a_wr_rdata_held", bus_a.rdata, 0);
        @(negedge clk);
        chk("a_wr_rdy_pulse", bus_a.rdy, 0);

        bus_a.ram_ena = 1; bus_a.ram_read = 1; bus_a.ad_sel = 1; bus_a.ir_addr = 13'h0010;
        @(negedge clk);
        chk("a_rd_busy", bus_a.busy, 1);
        bus_a.ram_ena = 0; bus_a.ram_read = 0; bus_a.ir_addr = 0;
        @(negedge clk);
        chk("a_rd_rdy", bus_a.rdy, 1);
        chk("a_rd_rdata", bus_a.rdata, 8'hA5);
        chk("a_rd_busy_end", bus_a.busy, 0);
        @(negedge clk);

        // ---- DUT A ROM fetch at pc_addr 0x0004, latency 3
        bus_a.rom_ena = 1; bus_a.rom_read = 1; bus_a.ad_sel = 0;
        bus_a.pc_addr = 13'h0004; bus_a.ir_addr = 13'h0123;
        @(negedge clk);
        chk("a_rom_rd", bus_a.rom_rd, 1);
        chk("a_rom_addr", bus_a.rom_addr, 13'h0004);
        chk("a_rom_busy", bus_a.busy, 1);
        bus_a.rom_ena = 0; bus_a.rom_read = 0; bus_a.pc_addr = 0; bus_a.ir_addr = 0;
        @(negedge clk);
        chk("a_rom_rd_pulse", bus_a.rom_rd, 0);
        chk("a_rom_rdy_e1", bus_a.rdy, 0);
        @(negedge clk);
        chk("a_rom_rdy_e2", bus_a.rdy, 0);
        chk("a_rom_busy_e2", bus_a.busy, 1);
        @(negedge clk);
        chk("a_rom_rdy", bus_a.rdy, 1);
        chk("a_rom_rdata", bus_a.rdata, 8'h3C);
        chk("a_rom_busy_end", bus_a.busy, 0);
        @(negedge clk);
        chk("a_rom_rdy_pulse", bus_a.rdy, 0);
        chk("a_rom_rdata_held", bus_a.rdata, 8'h3C);

        // ---- DUT A illegal RAM strobe (read and write together)
        bus_a.ram_ena = 1; bus_a.ram_read = 1; bus_a.ram_write = 1;
        bus_a.ad_sel = 1; bus_a.ir_addr = 13'h0010; bus_a.wdata = 8'h00;
        @(negedge clk);
        chk("a_ill_err", bus_a.err, 1);
        chk("a_ill_busy", bus_a.busy, 0);
        bus_a.ram_ena = 0; bus_a.ram_read = 0; bus_a.ram_write = 0;
        @(negedge clk);
        chk("a_ill_rdy", bus_a.rdy, 0);
        chk("a_ill_busy2", bus_a.busy, 0);
        bus_a.ram_ena = 1; bus_a.ram_read = 1;
        @(negedge clk);
        bus_a.ram_ena = 0; bus_a.ram_read = 0;
        @(negedge clk);
        chk("a_ill_ram_kept_rdy", bus_a.rdy, 1);
        chk("a_ill_ram_kept", bus_a.rdata, 8'hA5);
        chk("a_err_sticky", bus_a.err, 1);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("a_err_cleared", bus_a.err, 0);
        chk("a_rdata_cleared", bus_a.rdata, 0);
        @(negedge clk);
        rst_a = 1'b0;

        // ---- DUT B (RAM_WS=2): RAM write 77 to 0x0005 together with a ROM request
        bus_b.ram_ena = 1; bus_b.ram_write = 1; bus_b.ad_sel = 0;
        bus_b.pc_addr = 13'h0005; bus_b.wdata = 8'h77;
        bus_b.rom_ena = 1; bus_b.rom_read = 1;
        @(negedge clk);
        chk("b_both_err", bus_b.err, 1);
        chk("b_both_busy", bus_b.busy, 1);
        chk("b_both_rom_rd", bus_b.rom_rd, 0);
        bus_b.ram_ena = 0; bus_b.ram_write = 0; bus_b.rom_ena = 0; bus_b.rom_read = 0;
        bus_b.pc_addr = 0; bus_b.wdata = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("b_both_rom_rd_wait", bus_b.rom_rd, 0);
            chk("b_both_rdy_wait", bus_b.rdy, 0);
        end
        @(negedge clk);
        chk("b_both_rdy", bus_b.rdy, 1);
        chk("b_both_rom_rd_end", bus_b.rom_rd, 0);
        @(negedge clk);

        bus_b.ram_ena = 1; bus_b.ram_read = 1; bus_b.ad_sel = 1; bus_b.ir_addr = 13'h1F05;
        @(negedge clk);
        chk("b_wrap_busy", bus_b.busy, 1);
        bus_b.ram_ena = 0; bus_b.ram_read = 0; bus_b.ir_addr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("b_wrap_rdy_e2", bus_b.rdy, 0);
        @(negedge clk);
        chk("b_wrap_rdy", bus_b.rdy, 1);
        chk("b_wrap_rdata", bus_b.rdata, 8'h77);
        @(negedge clk);

        // ---- DUT C (RAM_WS=3): preload 00 at addr 2, ROM fetch, then aborted write of FF
        bus_c.ram_ena = 1; bus_c.ram_write = 1; bus_c.ad_sel = 0;
        bus_c.pc_addr = 13'h0002; bus_c.wdata = 8'h00;
        @(negedge clk);
        bus_c.ram_ena = 0; bus_c.ram_write = 0;
        repeat (3) @(negedge clk);
        chk("c_pre_rdy_e3", bus_c.rdy, 0);
        @(negedge clk);
        chk("c_pre_rdy", bus_c.rdy, 1);
        @(negedge clk);

        bus_c.rom_ena = 1; bus_c.rom_read = 1; bus_c.pc_addr = 13'h0007;
        @(negedge clk);
        chk("c_rom_addr", bus_c.rom_addr, 13'h0007);
        bus_c.rom_ena = 0; bus_c.rom_read = 0;
        @(negedge clk);
        chk("c_rom_rdy", bus_c.rdy, 1);
        chk("c_rom_rdata", bus_c.rdata, 8'h3F);
        @(negedge clk);

        bus_c.ram_ena = 1; bus_c.ram_write = 1; bus_c.pc_addr = 13'h0002; bus_c.wdata = 8'hFF;
        @(negedge clk);
        bus_c.ram_ena = 0; bus_c.ram_write = 0; bus_c.wdata = 0;
        @(negedge clk);
        chk("c_abort_busy_before", bus_c.busy, 1);
        @(posedge clk);
        #1;
        rst_c = 1'b1;
        #1;
        chk("c_abort_busy", bus_c.busy, 0);
        chk("c_abort_rdy", bus_c.rdy, 0);
        chk("c_abort_rdata", bus_c.rdata, 0);
        chk("c_abort_rom_addr", bus_c.rom_addr, 0);
        chk("c_abort_rom_rd", bus_c.rom_rd, 0);
        chk("c_abort_err", bus_c.err, 0);
        @(negedge clk);
        @(negedge clk);
        chk("c_abort_rdy_in_rst", bus_c.rdy, 0);
        rst_c = 1'b0;
        @(negedge clk);

        bus_c.ram_ena = 1; bus_c.ram_read = 1; bus_c.pc_addr = 13'h0002;
        @(negedge clk);
        bus_c.ram_ena = 0; bus_c.ram_read = 0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("c_after_rdy", bus_c.rdy, 1);
        chk("c_after_rdata", bus_c.rdata, 8'h00);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
